// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
// Command-driven controller that owns a 5-bit feedback shift register made of
// a 4-bit shift word x and a feedback bit f. One step performs
//   x <= {f, x[3:1]};  f <= x[3] ^ x[0];
// Commands (LOAD / RUN / PERIOD) arrive over a valid/ready handshake, and each
// command produces exactly one result over a second valid/ready handshake.
//
// Ports
//   clock        system clock, all state updates on posedge
//   reset        synchronous, active-high
//   cmd_valid    command present
//   cmd_ready    controller can accept a command (IDLE only)
//   cmd_op       00 LOAD, 01 RUN, 10 PERIOD, 11 reserved
//   cmd_seed     LOAD value {f, x[3:0]}
//   cmd_count    RUN step count
//   abort        terminate an active RUN or PERIOD
//   res_valid    result available (DONE)
//   res_ready    consumer takes result
//   res_count    steps performed, or measured period
//   res_flags    {err, lockup, aborted}
//   x, f         current register contents
//   busy         high in RUN or MEAS
module lfsr_seq_ctrl #(
  parameter logic       F0    = 1'b1,
  parameter logic [3:0] X0    = 4'h0,
  parameter int         CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_seed,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [2:0]       res_flags,
  output logic [3:0]       x,
  output logic             f,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_PERIOD = 2'b10;

  state_t           state, state_n;
  logic [3:0]       x_n;
  logic             f_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] target, target_n;
  logic [4:0]       start, start_n;
  logic [CNT_W-1:0] rcount_n;
  logic [2:0]       rflags_n;

  // Next register contents as {f, x} after one step.
  logic [4:0]       stepped;
  logic [CNT_W-1:0] cnt_inc;

  assign stepped = {x[3] ^ x[0], f, x[3:1]};
  assign cnt_inc = cnt + CNT_W'(1);

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == MEAS);

  // State and datapath registers; reset wins over every other input and
  // drops any pending result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      x         <= X0;
      f         <= F0;
      cnt       <= '0;
      target    <= '0;
      start     <= '0;
      res_count <= '0;
      res_flags <= '0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      f         <= f_n;
      cnt       <= cnt_n;
      target    <= target_n;
      start     <= start_n;
      res_count <= rcount_n;
      res_flags <= rflags_n;
    end
  end

  // Next-state and datapath decisions. Everything holds by default, so the
  // register only moves on an explicit step or LOAD.
  always_comb begin
    state_n  = state;
    x_n      = x;
    f_n      = f;
    cnt_n    = cnt;
    target_n = target;
    start_n  = start;
    rcount_n = res_count;
    rflags_n = res_flags;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              {f_n, x_n} = cmd_seed;
              rcount_n   = '0;
              rflags_n   = 3'b000;
              state_n    = DONE;
            end
            OP_RUN: begin
              cnt_n    = '0;
              rflags_n = 3'b000;
              if (cmd_count == '0) begin
                rcount_n = '0;
                state_n  = DONE;
              end else begin
                target_n = cmd_count;
                state_n  = RUN;
              end
            end
            OP_PERIOD: begin
              start_n  = {f, x};
              cnt_n    = '0;
              rflags_n = 3'b000;
              state_n  = MEAS;
            end
            default: begin
              rcount_n = '0;
              rflags_n = 3'b100;
              state_n  = DONE;
            end
          endcase
        end
      end

      RUN: begin
        // Abort suppresses the step that would otherwise happen on this edge.
        if (abort) begin
          rcount_n = cnt;
          rflags_n = 3'b001;
          state_n  = DONE;
        end else begin
          {f_n, x_n} = stepped;
          cnt_n      = cnt_inc;
          if (cnt_inc == target) begin
            rcount_n = cnt_inc;
            state_n  = DONE;
          end
        end
      end

      MEAS: begin
        if (abort) begin
          rcount_n = cnt;
          rflags_n = 3'b001;
          state_n  = DONE;
        end else begin
          {f_n, x_n} = stepped;
          cnt_n      = cnt_inc;
          // The all-zero state steps to itself, so it matches after one step
          // and is reported as a lockup.
          if (stepped == start) begin
            rcount_n = cnt_inc;
            rflags_n = {1'b0, (start == 5'b00000), 1'b0};
            state_n  = DONE;
          end else if (cnt_inc == '1) begin
            rcount_n = '1;
            rflags_n = 3'b100;
            state_n  = DONE;
          end
        end
      end

      DONE: begin
        if (res_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl
// Directed bench for lfsr_seq_ctrl. Inputs change and outputs are sampled on
// the falling clock edge, half a cycle away from the active rising edge.
module tb_lfsr_seq_ctrl;

  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [4:0]       cmd_seed;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [2:0]       res_flags;
  logic [3:0]       x;
  logic             f;
  logic             busy;

  int checks;
  int failures;

  lfsr_seq_ctrl #(
    .F0    (1'b1),
    .X0    (4'h0),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_seed  (cmd_seed),
    .cmd_count (cmd_count),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_flags (res_flags),
    .x         (x),
    .f         (f),
    .busy      (busy)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to the next falling edge
  task automatic tick();
    @(negedge clock);
  endtask

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one command for a single cycle; returns on the falling edge
  // after the accepting rising edge
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] seed,
                               input logic [CNT_W-1:0] count);
    cmd_op    = op;
    cmd_seed  = seed;
    cmd_count = count;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a result to appear
  task automatic waitResult(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, res_valid}, 32'd1);
  endtask

  // Take the pending result in one cycle
  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Hand-computed sequence from reset ({f,x} = 1_0000)
  logic [4:0] seq [0:4];

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_seed  = 5'd0;
    cmd_count = '0;
    abort     = 1'b0;
    res_ready = 1'b0;

    seq[0] = 5'b1_0000;
    seq[1] = 5'b0_1000;
    seq[2] = 5'b1_0100;
    seq[3] = 5'b0_1010;
    seq[4] = 5'b1_0101;

    tick();
    doReset();

    // Reset state
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_res_count", {24'd0, res_count}, 32'd0);
    checkOutput("rst_res_flags", {29'd0, res_flags}, 32'd0);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("rst_fx",        {27'd0, f, x},      32'b1_0000);

    // RUN 4 with the consumer always ready
    res_ready = 1'b1;
    applyStimulus(2'b01, 5'd0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("run4_fx_%0d", i), {27'd0, f, x}, {27'd0, seq[i]});
      checkOutput($sformatf("run4_busy_%0d", i), {31'd0, busy}, 32'd1);
      tick();
    end
    checkOutput("run4_fx_final", {27'd0, f, x},      {27'd0, seq[4]});
    checkOutput("run4_busy_end", {31'd0, busy},      32'd0);
    checkOutput("run4_valid",    {31'd0, res_valid}, 32'd1);
    checkOutput("run4_count",    {24'd0, res_count}, 32'd4);
    checkOutput("run4_flags",    {29'd0, res_flags}, 32'd0);
    tick();
    res_ready = 1'b0;
    checkOutput("run4_back_idle", {31'd0, cmd_ready}, 32'd1);

    // PERIOD from reset state: maximal length 31
    doReset();
    applyStimulus(2'b10, 5'd0, 8'd0);
    waitResult("per_timeout");
    checkOutput("per_count", {24'd0, res_count}, 32'd31);
    checkOutput("per_flags", {29'd0, res_flags}, 32'd0);
    checkOutput("per_fx",    {27'd0, f, x},      32'b1_0000);
    consume();

    // LOAD all-zero seed, then PERIOD reports lockup
    applyStimulus(2'b00, 5'b00000, 8'd0);
    checkOutput("load_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("load_count", {24'd0, res_count}, 32'd0);
    checkOutput("load_flags", {29'd0, res_flags}, 32'd0);
    checkOutput("load_fx",    {27'd0, f, x},      32'd0);
    consume();
    checkOutput("load_idle", {31'd0, cmd_ready}, 32'd1);
    applyStimulus(2'b10, 5'd0, 8'd0);
    waitResult("lock_timeout");
    checkOutput("lock_count", {24'd0, res_count}, 32'd1);
    checkOutput("lock_flags", {29'd0, res_flags}, 32'b010);
    checkOutput("lock_fx",    {27'd0, f, x},      32'd0);
    consume();

    // RUN 200 aborted after 10 steps
    doReset();
    applyStimulus(2'b01, 5'd0, 8'd200);
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("abort_count", {24'd0, res_count}, 32'd10);
    checkOutput("abort_flags", {29'd0, res_flags}, 32'b001);
    checkOutput("abort_fx",    {27'd0, f, x},      32'b0_1101);
    consume();

    // Reserved op, result held for 5 cycles with the consumer stalled
    applyStimulus(2'b11, 5'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rsv_valid_%0d", i), {31'd0, res_valid}, 32'd1);
      checkOutput($sformatf("rsv_ready_%0d", i), {31'd0, cmd_ready}, 32'd0);
      checkOutput($sformatf("rsv_count_%0d", i), {24'd0, res_count}, 32'd0);
      checkOutput($sformatf("rsv_flags_%0d", i), {29'd0, res_flags}, 32'b100);
      checkOutput($sformatf("rsv_fx_%0d", i),    {27'd0, f, x},      32'b0_1101);
      tick();
    end

    // A LOAD offered during the consuming cycle must not be taken
    cmd_op    = 2'b00;
    cmd_seed  = 5'b10101;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checkOutput("nocmd_idle", {31'd0, cmd_ready}, 32'd1);
    checkOutput("nocmd_fx",   {27'd0, f, x},      32'b0_1101);

    // Reset in the middle of PERIOD
    applyStimulus(2'b10, 5'd0, 8'd0);
    tick();
    tick();
    checkOutput("midper_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_fx",    {27'd0, f, x},      32'b1_0000);
    checkOutput("midrst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("midrst_busy",  {31'd0, busy},      32'd0);
    reset = 1'b0;
    tick();

    // RUN with count 0: immediate result, no step
    applyStimulus(2'b01, 5'd0, 8'd0);
    checkOutput("run0_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("run0_count", {24'd0, res_count}, 32'd0);
    checkOutput("run0_flags", {29'd0, res_flags}, 32'd0);
    checkOutput("run0_fx",    {27'd0, f, x},      32'b1_0000);
    consume();
    checkOutput("run0_idle", {31'd0, cmd_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Command-driven controller that owns and sequences a 5-bit feedback shift register.
- The register is a 4-bit shift word x plus one feedback bit f. Each step: x <= {f, x[3:1]}; f <= x[3]^x[0].
- Accepts LOAD, RUN and PERIOD commands over a valid/ready handshake and returns one result per command over a second valid/ready handshake.
- Used by lab benches to seed, advance and characterise the shift-register sequence without manual clock stepping.

Parameters:
- F0, 1, reset value of feedback bit f.
- X0, 4'h0, reset value of shift word x.
- CNT_W, 8, width of step counters, cmd_count and result_count.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 LOAD, 01 RUN, 10 PERIOD, 11 reserved.
- cmd_seed  input  5  LOAD value {f, x[3:0]}.
- cmd_count  input  CNT_W  RUN step count.
- abort  input  1  terminate an active RUN or PERIOD.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_count  output  CNT_W  steps performed, or measured period.
- res_flags  output  3  {err, lockup, aborted}.
- x  output  4  current shift word.
- f  output  1  current feedback bit.
- busy  output  1  high in RUN or MEAS.

Behaviour:
- Reset (synchronous, active-high):
  - x=X0, f=F0, state=IDLE.
  - cmd_ready=1, res_valid=0, res_count=0, res_flags=0, busy=0.
  - Reset overrides every other input in the same cycle. Reset mid-operation discards the pending result.
- States: IDLE, RUN, MEAS, DONE. cmd_ready=1 only in IDLE.
- A command is accepted on a cycle with cmd_valid&cmd_ready in IDLE.
- LOAD:
  - {f,x} <= cmd_seed on the accept edge.
  - Go to DONE with res_count=0, flags=0. Latency: res_valid high on the cycle after accept.
- RUN:
  - cmd_count=0: go straight to DONE with res_count=0 and no step.
  - Otherwise enter RUN. Exactly one step per cycle, starting on the first clock edge after accept.
  - Go to DONE after cmd_count steps; res_count=cmd_count. res_valid rises the cycle after the last step.
- PERIOD:
  - Latch start={f,x} on accept, then step once per cycle in MEAS with a counter.
  - When the post-step state equals start: res_count=steps, go to DONE.
  - If start==5'b00000: lockup=1, res_count=1 (the all-zero state maps to itself).
  - If the counter reaches 2^CNT_W-1 without a match: res_count=all ones, err=1.
  - Register is left at the final stepped state, which equals start on a match.
- Reserved op 11: no step; DONE with err=1, res_count=0.
- abort in RUN or MEAS:
  - The step on that edge is suppressed.
  - Go to DONE with aborted=1 and res_count=steps completed so far.
  - abort in IDLE or DONE is ignored.
- DONE:
  - res_valid=1. res_count and res_flags are stable until the handshake.
  - res_valid&res_ready returns to IDLE; cmd_ready=1 on the next cycle.
  - No command is accepted in the same cycle the result is consumed.
- Counter arithmetic is unsigned CNT_W bits with no wrap; saturation is handled by the err rule.
- busy=1 exactly in RUN and MEAS. x and f change only on steps or LOAD.

Test Plan:
- Reset, then RUN count=4 with res_ready=1 → steps visible on 4 consecutive edges; final x=4'b0101, f=1; res_count=4, flags=000; busy high for exactly 4 cycles.
- After reset, PERIOD → res_count=31, flags=000, final {f,x}={1,4'b0000}.
- LOAD seed 5'b00000, then PERIOD → res_count=1, flags=010, x=0, f=0.
- RUN count=200, assert abort after 10 steps → res_count=10, flags=001; x,f match the 10-step state from reset (x=4'b1101, f=0).
- cmd_op=11 → res_count=0, flags=100, x/f unchanged. Also: hold res_ready=0 for 5 cycles in DONE → res_valid and outputs stable, cmd_ready=0.
- Assert reset in the middle of PERIOD → next cycle x=0, f=1, res_valid=0, cmd_ready=1. Also: RUN count=0 → immediate result, res_count=0, no state change.
